// File: rtl/keypad_debounce_scan.sv
// 4x4 keypad row scanner with column synchronizer and press/release debounce.
// Emits one key_code/key_valid pulse per accepted physical press.
module keypad_debounce_scan #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_e;

  state_e        state_q;
  logic [3:0]    sync1_q;
  logic [3:0]    cols_s_q;
  logic [1:0]    row_q;
  logic [3:0]    rows_q;
  logic [SW-1:0] settle_q;
  logic [DW-1:0] db_q;
  logic [3:0]    cap_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  function automatic logic single_low(input logic [3:0] c);
    case (c)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] col_idx(input logic [3:0] c);
    case (c)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] key_map(
    input logic [1:0] r,
    input logic [3:0] c
  );
    case ({r, col_idx(c)})
      4'h0:    return 4'h1;
      4'h1:    return 4'h2;
      4'h2:    return 4'h3;
      4'h3:    return 4'hA;
      4'h4:    return 4'h4;
      4'h5:    return 4'h5;
      4'h6:    return 4'h6;
      4'h7:    return 4'hB;
      4'h8:    return 4'h7;
      4'h9:    return 4'h8;
      4'hA:    return 4'h9;
      4'hB:    return 4'hC;
      4'hC:    return 4'hE;
      4'hD:    return 4'h0;
      4'hE:    return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      sync1_q     <= 4'b1111;
      cols_s_q    <= 4'b1111;
      row_q       <= 2'd0;
      rows_q      <= 4'b1110;
      settle_q    <= '0;
      db_q        <= '0;
      cap_q       <= 4'b1111;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      sync1_q     <= columns;
      cols_s_q    <= sync1_q;
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (settle_q == SET_LAST) begin
            if (single_low(cols_s_q)) begin
              cap_q   <= cols_s_q;
              db_q    <= '0;
              state_q <= DEBOUNCE;
            end else begin
              row_q    <= row_q + 2'd1;
              rows_q   <= row_drive(row_q + 2'd1);
              settle_q <= '0;
            end
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (cols_s_q == cap_q) begin
            if (db_q == DB_LAST) begin
              key_code_q  <= key_map(row_q, cap_q);
              key_valid_q <= 1'b1;
              db_q        <= '0;
              state_q     <= HELD;
            end else begin
              db_q <= db_q + 1'b1;
            end
          end else begin
            // Bounce: rescan the same row from a fresh settle window
            settle_q <= '0;
            state_q  <= SCAN;
          end
        end
        HELD: begin
          if (cols_s_q == 4'b1111) begin
            if (db_q == DB_LAST) begin
              row_q    <= row_q + 2'd1;
              rows_q   <= row_drive(row_q + 2'd1);
              settle_q <= '0;
              db_q     <= '0;
              state_q  <= SCAN;
            end else begin
              db_q <= db_q + 1'b1;
            end
          end else begin
            db_q <= '0;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign rows      = rows_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_debounce_scan.sv
// Bench for keypad_debounce_scan: keypad matrix model, expected-code
// queue drained by a key_valid monitor, plus directed timing checks.
module tb_keypad_debounce_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] columns;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;

  logic [3:0][3:0] press;
  logic [3:0]      sb[$];
  logic [3:0]      exp_code;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  keypad_debounce_scan #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .columns  (columns),
    .rows     (rows),
    .key_code (key_code),
    .key_valid(key_valid)
  );

  // Pressed switch shorts its column to its row while that row is driven low
  always_comb begin
    columns = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r][c] && !rows[r]) columns[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset && key_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: key_code %h, no pulse wanted", key_code);
      end else begin
        exp_code = sb.pop_front();
        if (key_code !== exp_code) begin
          errors++;
          $display("FAIL pulse_code: got %h want %h", key_code, exp_code);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic wait_rows(input logic [3:0] val, input string nm);
    int n = 0;
    while (rows !== val && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(nm, rows, val);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d pulses missing, want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [3:0] er;
    press = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: idle scan, 4 cycles per row
    for (int i = 0; i < 16; i++) begin
      er = ~(4'b0001 << (i / 4));
      chk("t1_rows", rows, er);
      chk("t1_code", key_code, 4'h0);
      chk("t1_valid", {3'b000, key_valid}, 4'h0);
      @(negedge clk);
    end

    // 2: clean "5", exact latency from row 1 being driven
    wait_rows(4'b1011, "t2_row2");
    press[1][1] = 1'b1;
    sb.push_back(4'h5);
    wait_rows(4'b1101, "t2_row1");
    repeat (11) @(negedge clk);
    chk("t2_early", {3'b000, key_valid}, 4'h0);
    @(negedge clk);
    chk("t2_pulse", {3'b000, key_valid}, 4'h1);
    chk("t2_code", key_code, 4'h5);
    repeat (80) @(negedge clk);
    chk("t2_frozen", rows, 4'b1101);
    wait_drain("t2_drain");
    @(negedge clk);
    press = '0;
    repeat (20) @(negedge clk);

    // 3: bouncing contact, then stable
    for (int k = 0; k < 10; k++) begin
      press[1][1] = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    sb.push_back(4'h5);
    press[1][1] = 1'b1;
    wait_drain("t3_drain");
    @(negedge clk);
    chk("t3_frozen", rows, 4'b1101);
    press = '0;
    repeat (20) @(negedge clk);

    // 4: "A" held, "D" ignored, release resumes at row 1
    press[0][3] = 1'b1;
    sb.push_back(4'hA);
    wait_drain("t4_drain");
    @(negedge clk);
    press[3][3] = 1'b1;
    repeat (10) @(negedge clk);
    press[3][3] = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_frozen", rows, 4'b1110);
    press[0][3] = 1'b0;
    repeat (9) @(negedge clk);
    chk("t4_release_wait", rows, 4'b1110);
    @(negedge clk);
    chk("t4_resume", rows, 4'b1101);

    // 5: reset during DEBOUNCE of "0"
    wait_rows(4'b1110, "t5_row0");
    press[3][1] = 1'b1;
    wait_rows(4'b0111, "t5_row3");
    repeat (7) @(negedge clk);
    chk("t5_held_row", rows, 4'b0111);
    reset = 1'b1;
    press = '0;
    @(negedge clk);
    chk("t5_rows", rows, 4'b1110);
    chk("t5_code", key_code, 4'h0);
    chk("t5_valid", {3'b000, key_valid}, 4'h0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_code_after", key_code, 4'h0);

    // 6: "F" with release glitches, then "1"
    press[3][2] = 1'b1;
    sb.push_back(4'hF);
    wait_drain("t6_drain_f");
    @(negedge clk);
    press[3][2] = 1'b0;
    repeat (4) @(negedge clk);
    press[3][2] = 1'b1;
    repeat (6) @(negedge clk);
    press[3][2] = 1'b0;
    repeat (5) @(negedge clk);
    press[3][2] = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_frozen", rows, 4'b0111);
    press[3][2] = 1'b0;
    repeat (20) @(negedge clk);
    press[0][0] = 1'b1;
    sb.push_back(4'h1);
    wait_drain("t6_drain_1");
    @(negedge clk);
    chk("t6_code", key_code, 4'h1);
    press = '0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_debounce_scan.md
# keypad_debounce_scan

Drives the rows of a 4x4 matrix keypad, samples the columns, debounces a single key press and emits one hex code per physical press. It sits between the keypad pins and the two-digit value register / seven-segment display stage. That stage shifts the new code in on each `key_valid` pulse. Runs on the 48 MHz HSOSC clock.

## Interface
- `SETTLE_CYCLES`, default 16: clock cycles a row is driven before its columns are sampled. Must be ≥ 3 to cover the synchronizer.
- `DEBOUNCE_CYCLES`, default 960000 (20 ms at 48 MHz): stable cycles required to accept a press or a release.
- `clk` input 1: system clock, `int_osc` at top level.
- `reset` input 1: synchronous, active-high.
- `columns` input 4: raw keypad columns, active-low with pull-ups, asynchronous.
- `rows` output 4: row drive, active-low; exactly one bit is 0 at all times.
- `key_code` output 4: hex value of the last accepted key; holds its value between presses.
- `key_valid` output 1: one-cycle pulse in the cycle `key_code` updates.

## Operation
- Internal 2-FF synchronizer on `columns` gives `cols_s`. Only `cols_s` is used by the logic.
- `row_idx` (2 bits) drives the rows: `rows = ~(4'b0001 << row_idx)`.
- Counters: `settle_cnt` is $clog2(SETTLE_CYCLES) bits; `db_cnt` is $clog2(DEBOUNCE_CYCLES) bits. Both saturate, never wrap.
- Key map, as row:cols 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- State machine: SCAN, DEBOUNCE, HELD.
  - **SCAN.** `settle_cnt` counts up. The columns are sampled on the cycle where `settle_cnt == SETTLE_CYCLES-1`.
    - Exactly one bit of `cols_s` is 0: capture `row_idx` and the column pattern, clear `db_cnt`, go to DEBOUNCE. `row_idx` is held.
    - Otherwise, including all-high or more than one bit low: `row_idx <= row_idx+1` (3 wraps to 0), clear `settle_cnt`.
  - **DEBOUNCE.** Each cycle, `cols_s` is compared with the captured pattern.
    - Match and `db_cnt == DEBOUNCE_CYCLES-1`: load `key_code` from the map, pulse `key_valid`, clear `db_cnt`, go to HELD.
    - Match otherwise: `db_cnt++`.
    - Mismatch: go to SCAN on the same row with `settle_cnt` cleared. No output.
  - **HELD.** `row_idx` is frozen.
    - `cols_s == 4'b1111`: `db_cnt++`. On reaching `DEBOUNCE_CYCLES-1`, go to SCAN with `row_idx+1` and `settle_cnt` cleared.
    - Any low column: clear `db_cnt`.
    - Other keys pressed meanwhile are ignored; no second pulse until release is accepted.
- Reset values:
  - state SCAN, `row_idx` 0, so `rows = 4'b1110`
  - `key_code = 4'h0`, `key_valid = 0`
  - all counters and synchronizer flops cleared to their idle values; sync flops reset to `4'b1111`.

## Timing
- All outputs are registered. `rows` changes on the clock edge following the decision.
- Row dwell with no key present: exactly SETTLE_CYCLES cycles, so a full scan takes 4·SETTLE_CYCLES.
- Sample edge `t` is the SCAN sample cycle that detects the key. With the press stable from then on, `key_valid` is high in cycle `t + DEBOUNCE_CYCLES + 1`. `key_code` is valid in that same cycle.
- Pin to `cols_s` latency is 2 cycles. It is covered inside the settle window.
- Reset asserted in any state returns to the reset values on the next edge, including mid-DEBOUNCE. No pulse is emitted that cycle or after.
- A press whose low column stays stable for fewer than DEBOUNCE_CYCLES+1 cycles produces no pulse.
- A press and release on another row while HELD produces nothing.

## Test plan
Benches override `SETTLE_CYCLES=4` and `DEBOUNCE_CYCLES=8`. The keypad model connects the pressed row and column.

1. **Reset.** Assert `reset` for 2 cycles, then release with no keys -> `rows` cycles 1110, 1101, 1011, 0111 at 4 cycles each; `key_valid` stays 0; `key_code` stays 0.
2. **Clean press of "5"** (r1, c1), held 100 cycles -> exactly one `key_valid` pulse with `key_code = 4'h5`; `rows` frozen at 1101 until release.
3. **Bounce.** Toggle the c1 contact every 3 cycles for 30 cycles, then hold stable -> no pulse during bouncing; exactly one pulse with `key_code = 4'h5` 9 cycles after the last stable sample starts.
4. **Second key while held.** Hold "A" (r0, c3), then press "D" (r3, c3) and release "D" -> a single pulse with `key_code = 4'hA`. After "A" is released for 8 or more cycles, the scan resumes at row 1 (`rows = 1101`).
5. **Reset mid-DEBOUNCE.** Press "0" (r3, c1) and assert `reset` 4 cycles into DEBOUNCE -> no `key_valid`; `rows = 1110` the cycle after reset; `key_code = 0`.
6. **Release bounce.** Hold "F", then give two sub-8-cycle release glitches before the true release -> only one pulse with `key_code = 4'hF`; the next press of "1" yields `key_code = 4'h1`.
